// File: rtl/sump_cmd_parser.sv
// SUMP/OLS command framer: turns UART RX bytes into one strobed, classified command
// per short (opcode only) or long (opcode + DATA_BYTES payload) command.
module sump_cmd_parser #(
  parameter int unsigned DATA_BYTES     = 4,
  parameter int unsigned NUM_STAGES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                    clk_i,
  input  logic                    rst_in,
  input  logic [7:0]              rx_data_i,
  input  logic                    rx_stb_i,
  output logic                    cmd_stb_o,
  output logic [7:0]              opcode_o,
  output logic [8*DATA_BYTES-1:0] cmd_data_o,
  output logic [1:0]              stage_o,
  output logic                    unknown_o,
  output logic                    soft_rst_o,
  output logic                    err_timeout_o,
  output logic                    busy_o
);

  localparam int unsigned DW = 8 * DATA_BYTES;
  localparam int unsigned BW = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(DATA_BYTES - 1);
  localparam logic [TW-1:0] TO_LAST   = (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);
  localparam bit            TO_EN     = (TIMEOUT_CYCLES != 0);

  typedef enum logic {IDLE, PAYLOAD} state_t;

  state_t          state;
  logic [7:0]      pend_op;
  logic [DW-1:0]   shadow;
  logic [BW-1:0]   byte_cnt;
  logic [TW-1:0]   to_cnt;

  logic [7:0]      cls_op_c;
  logic            trig_c;
  logic            known_c;
  logic [DW-1:0]   next_data_c;

  // Classify whichever opcode is about to be emitted (live byte for short, latched for long)
  always_comb begin
    cls_op_c = (state == IDLE) ? rx_data_i : pend_op;
    trig_c   = (cls_op_c[7:4] == 4'hC) && (cls_op_c[1:0] != 2'b11) &&
               (32'(cls_op_c[3:2]) < NUM_STAGES);
    case (cls_op_c)
      8'h00, 8'h01, 8'h02, 8'h04, 8'h05, 8'h06, 8'h0F, 8'h11, 8'h13,
      8'h80, 8'h81, 8'h82, 8'h9E, 8'h9F: known_c = 1'b1;
      default:                           known_c = trig_c;
    endcase
  end

  // Shadow payload with the incoming byte merged into its slot
  always_comb begin
    next_data_c = shadow;
    next_data_c[8*byte_cnt +: 8] = rx_data_i;
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state         <= IDLE;
      pend_op       <= '0;
      shadow        <= '0;
      byte_cnt      <= '0;
      to_cnt        <= '0;
      cmd_stb_o     <= 1'b0;
      opcode_o      <= '0;
      cmd_data_o    <= '0;
      stage_o       <= '0;
      unknown_o     <= 1'b0;
      soft_rst_o    <= 1'b0;
      err_timeout_o <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      cmd_stb_o     <= 1'b0;
      soft_rst_o    <= 1'b0;
      err_timeout_o <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_stb_i) begin
            if (!rx_data_i[7]) begin
              cmd_stb_o  <= 1'b1;
              opcode_o   <= rx_data_i;
              cmd_data_o <= '0;
              unknown_o  <= !known_c;
              stage_o    <= trig_c ? rx_data_i[3:2] : 2'd0;
              soft_rst_o <= (rx_data_i == 8'h00);
            end else begin
              state    <= PAYLOAD;
              pend_op  <= rx_data_i;
              shadow   <= '0;
              byte_cnt <= '0;
              to_cnt   <= '0;
              busy_o   <= 1'b1;
            end
          end
        end
        PAYLOAD: begin
          if (rx_stb_i) begin
            shadow <= next_data_c;
            to_cnt <= '0;
            if (byte_cnt == LAST_BYTE) begin
              state      <= IDLE;
              busy_o     <= 1'b0;
              cmd_stb_o  <= 1'b1;
              opcode_o   <= pend_op;
              cmd_data_o <= next_data_c;
              unknown_o  <= !known_c;
              stage_o    <= trig_c ? pend_op[3:2] : 2'd0;
            end else begin
              byte_cnt <= byte_cnt + BW'(1);
            end
          end else if (TO_EN && (to_cnt == TO_LAST)) begin
            // Host went quiet mid-command: drop the partial command
            state         <= IDLE;
            busy_o        <= 1'b0;
            err_timeout_o <= 1'b1;
          end else if (TO_EN) begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sump_cmd_parser.sv
// Scoreboarded bench for sump_cmd_parser: expected commands are queued as bytes are
// driven and compared by a monitor whenever the parser strobes a command.
module tb_sump_cmd_parser;

  localparam int unsigned DATA_BYTES     = 4;
  localparam int unsigned NUM_STAGES     = 2;
  localparam int unsigned TIMEOUT_CYCLES = 16;

  typedef struct packed {
    logic [7:0]  op;
    logic [31:0] data;
    logic [1:0]  stage;
    logic        unk;
    logic        srst;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_stb;
  logic        cmd_stb_o;
  logic [7:0]  opcode_o;
  logic [31:0] cmd_data_o;
  logic [1:0]  stage_o;
  logic        unknown_o;
  logic        soft_rst_o;
  logic        err_timeout_o;
  logic        busy_o;

  exp_t sb[$];
  int   n_checks;
  int   n_errors;
  int   to_count;
  int   to_before;

  sump_cmd_parser #(
    .DATA_BYTES    (DATA_BYTES),
    .NUM_STAGES    (NUM_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk_i        (clk),
    .rst_in       (rst_n),
    .rx_data_i    (rx_data),
    .rx_stb_i     (rx_stb),
    .cmd_stb_o    (cmd_stb_o),
    .opcode_o     (opcode_o),
    .cmd_data_o   (cmd_data_o),
    .stage_o      (stage_o),
    .unknown_o    (unknown_o),
    .soft_rst_o   (soft_rst_o),
    .err_timeout_o(err_timeout_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: pops the scoreboard on every command strobe, counts timeout pulses
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (cmd_stb_o) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_strobe got op=%h data=%h, expected no strobe", opcode_o, cmd_data_o);
        end else begin
          e = sb.pop_front();
          if ({opcode_o, cmd_data_o, stage_o, unknown_o, soft_rst_o} !== e) begin
            n_errors++;
            $display("FAIL cmd_compare got op=%h data=%h stage=%0d unk=%b srst=%b, expected op=%h data=%h stage=%0d unk=%b srst=%b",
                     opcode_o, cmd_data_o, stage_o, unknown_o, soft_rst_o, e.op, e.data, e.stage, e.unk, e.srst);
          end
        end
      end else if (soft_rst_o) begin
        n_checks++;
        n_errors++;
        $display("FAIL soft_rst_alone got soft_rst_o=1 without cmd_stb_o, expected 0");
      end
      if (err_timeout_o) to_count++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout, expected bench to finish");
    $fatal(1, "watchdog expired");
  end

  // Drive one byte; returns 1 time unit after the edge that sampled it
  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_stb  = 1'b1;
    @(posedge clk);
    #1;
    rx_stb  = 1'b0;
  endtask

  task automatic send_long(input logic [7:0] op, input logic [31:0] d);
    send(op);
    for (int i = 0; i < 4; i++) send(d[8*i +: 8]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; rx_stb = 1'b0; rx_data = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({cmd_stb_o, opcode_o, cmd_data_o, stage_o, unknown_o, soft_rst_o, err_timeout_o, busy_o} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs got stb=%b op=%h data=%h busy=%b, expected all 0", cmd_stb_o, opcode_o, cmd_data_o, busy_o);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_short;
    sb.push_back('{op: 8'h02, data: 32'h0, stage: 2'd0, unk: 1'b0, srst: 1'b0});
    send(8'h02);
    n_checks++;
    if (cmd_stb_o !== 1'b1) begin
      n_errors++;
      $display("FAIL short_latency got cmd_stb_o=%b, expected 1 one cycle after byte", cmd_stb_o);
    end
    sb.push_back('{op: 8'h03, data: 32'h0, stage: 2'd0, unk: 1'b1, srst: 1'b0});
    send(8'h03);
    idle(2);
    n_checks++;
    if (sb.size() !== 0) begin
      n_errors++;
      $display("FAIL short_drain got %0d pending, expected 0", sb.size());
    end
  endtask

  task automatic test_long;
    send(8'h80);
    n_checks++;
    if (busy_o !== 1'b1) begin
      n_errors++;
      $display("FAIL long_busy_set got busy_o=%b, expected 1", busy_o);
    end
    send(8'h10); send(8'h32); send(8'h54);
    n_checks++;
    if (busy_o !== 1'b1 || cmd_data_o !== 32'h0) begin
      n_errors++;
      $display("FAIL long_midway got busy=%b data=%h, expected busy=1 data=00000000", busy_o, cmd_data_o);
    end
    sb.push_back('{op: 8'h80, data: 32'h7654_3210, stage: 2'd0, unk: 1'b0, srst: 1'b0});
    send(8'h76);
    n_checks++;
    if (busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL long_busy_clr got busy_o=%b, expected 0", busy_o);
    end
    idle(3);
    n_checks++;
    if (cmd_data_o !== 32'h7654_3210 || opcode_o !== 8'h80 || sb.size() !== 0) begin
      n_errors++;
      $display("FAIL long_hold got op=%h data=%h pending=%0d, expected op=80 data=76543210 pending=0", opcode_o, cmd_data_o, sb.size());
    end
  endtask

  task automatic test_flush_timeout;
    to_before = to_count;
    send(8'h81); send(8'h00); send(8'h00);
    idle(TIMEOUT_CYCLES - 1);
    n_checks++;
    if (err_timeout_o !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_early got err_timeout_o=%b, expected 0", err_timeout_o);
    end
    idle(1);
    n_checks++;
    if (err_timeout_o !== 1'b1 || busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL timeout_pulse got err=%b busy=%b, expected err=1 busy=0", err_timeout_o, busy_o);
    end
    idle(3);
    n_checks++;
    if (to_count - to_before !== 1) begin
      n_errors++;
      $display("FAIL timeout_count got %0d pulses, expected 1", to_count - to_before);
    end
    sb.push_back('{op: 8'h00, data: 32'h0, stage: 2'd0, unk: 1'b0, srst: 1'b1});
    send(8'h00);
    n_checks++;
    if (soft_rst_o !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_soft_rst got soft_rst_o=%b, expected 1", soft_rst_o);
    end
    idle(2);
  endtask

  // Every payload byte lands exactly on the terminal count cycle
  task automatic test_terminal_byte;
    logic [31:0] d;
    d = 32'hD4C3_B2A1;
    to_before = to_count;
    send(8'h81);
    for (int i = 0; i < 4; i++) begin
      repeat (TIMEOUT_CYCLES - 1) @(posedge clk);
      #1;
      if (i == 3) sb.push_back('{op: 8'h81, data: d, stage: 2'd0, unk: 1'b0, srst: 1'b0});
      send(d[8*i +: 8]);
    end
    idle(3);
    n_checks++;
    if (to_count !== to_before || sb.size() !== 0) begin
      n_errors++;
      $display("FAIL terminal_byte got %0d timeouts pending=%0d, expected 0 timeouts pending=0", to_count - to_before, sb.size());
    end
  endtask

  task automatic test_stages;
    sb.push_back('{op: 8'hC4, data: 32'h0403_0201, stage: 2'd1, unk: 1'b0, srst: 1'b0});
    send_long(8'hC4, 32'h0403_0201);
    sb.push_back('{op: 8'hC8, data: 32'hAABB_CCDD, stage: 2'd0, unk: 1'b1, srst: 1'b0});
    send_long(8'hC8, 32'hAABB_CCDD);
    sb.push_back('{op: 8'hC3, data: 32'h0000_00FF, stage: 2'd0, unk: 1'b1, srst: 1'b0});
    send_long(8'hC3, 32'h0000_00FF);
    sb.push_back('{op: 8'hC6, data: 32'h1234_5678, stage: 2'd1, unk: 1'b0, srst: 1'b0});
    send_long(8'hC6, 32'h1234_5678);
    sb.push_back('{op: 8'hC1, data: 32'h8000_0001, stage: 2'd0, unk: 1'b0, srst: 1'b0});
    send_long(8'hC1, 32'h8000_0001);
    sb.push_back('{op: 8'h9F, data: 32'h0000_0000, stage: 2'd0, unk: 1'b0, srst: 1'b0});
    send_long(8'h9F, 32'h0000_0000);
    sb.push_back('{op: 8'h83, data: 32'hCAFE_F00D, stage: 2'd0, unk: 1'b1, srst: 1'b0});
    send_long(8'h83, 32'hCAFE_F00D);
    sb.push_back('{op: 8'h11, data: 32'h0, stage: 2'd0, unk: 1'b0, srst: 1'b0});
    send(8'h11);
    idle(2);
    n_checks++;
    if (sb.size() !== 0) begin
      n_errors++;
      $display("FAIL stages_drain got %0d pending, expected 0", sb.size());
    end
  endtask

  task automatic test_back_to_back_zeros;
    sb.push_back('{op: 8'h82, data: 32'h0, stage: 2'd0, unk: 1'b0, srst: 1'b0});
    sb.push_back('{op: 8'h00, data: 32'h0, stage: 2'd0, unk: 1'b0, srst: 1'b1});
    send(8'h82);
    for (int i = 0; i < 5; i++) send(8'h00);
    idle(2);
    n_checks++;
    if (sb.size() !== 0) begin
      n_errors++;
      $display("FAIL zeros_drain got %0d pending, expected 0", sb.size());
    end
  endtask

  task automatic test_reset_mid;
    send(8'h82); send(8'hAA); send(8'hBB);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy_o !== 1'b0 || opcode_o !== 8'h00 || cmd_data_o !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_mid got busy=%b op=%h data=%h, expected 0", busy_o, opcode_o, cmd_data_o);
    end
    idle(2);
    rst_n = 1'b1;
    idle(3);
    sb.push_back('{op: 8'h11, data: 32'h0, stage: 2'd0, unk: 1'b0, srst: 1'b0});
    send(8'h11);
    idle(3);
    n_checks++;
    if (sb.size() !== 0 || busy_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_mid_after got pending=%0d busy=%b, expected 0 and 0", sb.size(), busy_o);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    to_count = 0;
    test_reset();
    test_short();
    test_long();
    test_flush_timeout();
    test_terminal_byte();
    test_stages();
    test_back_to_back_zeros();
    test_reset_mid();
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
